cas_tape_player: RTL and testbench

- Replays a cassette image held in a byte-wide memory as a square-wave tape signal into the console's tape input (AUDIO_INPUT path).
- Upstream of the console core: loader/SDRAM side feeds bytes, this block serialises them with leader, framing and bit timing.
- Honours the fast-load option (casSpeed) and motor gating.

---
 rtl/tape_pkg.sv | 27 ++
 rtl/tape_bit_cell.sv | 50 +++++
 rtl/cas_tape_player.sv | 251 +++++++++++++++++++++++++
 tb/tb_cas_tape_player.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
// Shared definitions for the cassette tape player: playback states,
// byte-frame geometry and the fast-load half-period helper.
package tape_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEADER,
      START,
      DATA,
      STOP,
      WAIT,
      DONE
   } tape_state_t;

   localparam int START_BITS = 1;
   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 2;
   localparam int FAST_SHIFT = 2;

   // Fast-load half period: divided down, but never shorter than one cycle.
   function automatic int fast_half(input int half);
      int h;
      h = half >> FAST_SHIFT;
      return (h < 1) ? 1 : h;
   endfunction

endpackage

// File: rtl/tape_bit_cell.sv
// One tape bit cell: level is high for H cycles then low for H cycles,
// with H chosen from the bit value when the cell is loaded. cell_end pulses
// on the last cycle of the cell so the next cell can be loaded without a gap.
module tape_bit_cell #(
   parameter int HALF_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              load,
   input  logic              bit_val,
   input  logic [HALF_W-1:0] half0,
   input  logic [HALF_W-1:0] half1,
   output logic              level,
   output logic              cell_end
);

   localparam int CNT_W = HALF_W + 1;

   logic [CNT_W-1:0]  cnt;
   logic [HALF_W-1:0] half_q;
   logic              active;
   logic [CNT_W-1:0]  period_m1;

   assign period_m1 = {half_q, 1'b0} - CNT_W'(1);
   assign level     = active && (cnt < {1'b0, half_q});
   assign cell_end  = active && enable && (cnt == period_m1);

   // Cell counter: a load starts a fresh cell; otherwise advance while enabled
   // and retire the cell after its final cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         half_q <= '0;
         active <= 1'b0;
      end else if (load) begin
         cnt    <= '0;
         half_q <= bit_val ? half1 : half0;
         active <= 1'b1;
      end else if (enable && active) begin
         if (cell_end) begin
            active <= 1'b0;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/cas_tape_player.sv
// Cassette image player: fetches bytes from a byte-wide memory one at a time
// and serialises them as leader tone plus start/data/stop framed bit cells.
module cas_tape_player
   import tape_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int HALF0_CYC   = 1200,
   parameter int HALF1_CYC   = 600,
   parameter int LEADER_BITS = 2048
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] tape_len,
   input  logic              fast_i,
   input  logic              motor_i,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_data,
   output logic              tape_out,
   output logic              busy,
   output logic              done
);

   localparam int HALF_MAX = (HALF0_CYC > HALF1_CYC) ? HALF0_CYC : HALF1_CYC;
   localparam int HALF_W   = $clog2(HALF_MAX + 1);
   localparam int BIT_MAX  = (LEADER_BITS > DATA_BITS) ? LEADER_BITS : DATA_BITS;
   localparam int BIT_W    = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
   localparam int H0_FAST  = fast_half(HALF0_CYC);
   localparam int H1_FAST  = fast_half(HALF1_CYC);

   tape_state_t       state;
   tape_state_t       state_next;

   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] byte_idx;
   logic [BIT_W-1:0]  bit_cnt;
   logic [7:0]        shreg;
   logic [7:0]        buf_data;
   logic              buf_valid;

   logic              cell_load;
   logic              cell_bit;
   logic              cell_level;
   logic              cell_end;
   logic [HALF_W-1:0] half0;
   logic [HALF_W-1:0] half1;

   logic              accept;
   logic              consume;
   logic              byte_adv;
   logic              cnt_clr;
   logic              cnt_inc;
   logic              shift_en;

   logic              ack_hit;
   logic              data_ready;
   logic              last_byte;

   assign half0 = fast_i ? HALF_W'(H0_FAST) : HALF_W'(HALF0_CYC);
   assign half1 = fast_i ? HALF_W'(H1_FAST) : HALF_W'(HALF1_CYC);

   // An ack only counts while a read is outstanding; its data may start a
   // byte in the same cycle it arrives.
   assign ack_hit    = mem_rd && mem_ack;
   assign data_ready = buf_valid || ack_hit;
   assign last_byte  = ((byte_idx + ADDR_W'(1)) == len_q);

   assign tape_out = cell_level;
   assign busy     = (state != IDLE) && (state != DONE);
   assign done     = (state == DONE);

   tape_bit_cell #(
      .HALF_W (HALF_W)
   ) u_cell (
      .clk      (clk_sys),
      .reset    (reset),
      .enable   (motor_i),
      .load     (cell_load),
      .bit_val  (cell_bit),
      .half0    (half0),
      .half1    (half1),
      .level    (cell_level),
      .cell_end (cell_end)
   );

   // Playback state register.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: decides at each cell boundary which cell follows and
   // raises the bookkeeping strobes for the datapath below.
   always_comb begin
      state_next = state;
      cell_load  = 1'b0;
      cell_bit   = 1'b1;
      accept     = 1'b0;
      consume    = 1'b0;
      byte_adv   = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      shift_en   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (tape_len != '0) begin
                  accept     = 1'b1;
                  cell_load  = 1'b1;
                  cell_bit   = 1'b1;
                  cnt_clr    = 1'b1;
                  state_next = LEADER;
               end else begin
                  state_next = DONE;
               end
            end
         end
         LEADER: begin
            if (cell_end) begin
               if (bit_cnt == BIT_W'(LEADER_BITS - 1)) begin
                  cnt_clr = 1'b1;
                  if (data_ready) begin
                     cell_load  = 1'b1;
                     cell_bit   = 1'b0;
                     state_next = START;
                  end else begin
                     state_next = WAIT;
                  end
               end else begin
                  cnt_inc   = 1'b1;
                  cell_load = 1'b1;
                  cell_bit  = 1'b1;
               end
            end
         end
         START: begin
            if (cell_end) begin
               consume    = 1'b1;
               cnt_clr    = 1'b1;
               cell_load  = 1'b1;
               cell_bit   = buf_data[0];
               state_next = DATA;
            end
         end
         DATA: begin
            if (cell_end) begin
               if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                  cnt_clr    = 1'b1;
                  cell_load  = 1'b1;
                  cell_bit   = 1'b1;
                  state_next = STOP;
               end else begin
                  cnt_inc   = 1'b1;
                  shift_en  = 1'b1;
                  cell_load = 1'b1;
                  cell_bit  = shreg[0];
               end
            end
         end
         STOP: begin
            if (cell_end) begin
               if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                  cnt_clr = 1'b1;
                  if (last_byte) begin
                     state_next = DONE;
                  end else begin
                     byte_adv = 1'b1;
                     if (data_ready) begin
                        cell_load  = 1'b1;
                        cell_bit   = 1'b0;
                        state_next = START;
                     end else begin
                        state_next = WAIT;
                     end
                  end
               end else begin
                  cnt_inc   = 1'b1;
                  cell_load = 1'b1;
                  cell_bit  = 1'b1;
               end
            end
         end
         WAIT: begin
            if (motor_i && data_ready) begin
               cell_load  = 1'b1;
               cell_bit   = 1'b0;
               state_next = START;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Fetch, byte buffer and bit bookkeeping: one read outstanding at most,
   // the next byte is requested as soon as the current one is unloaded.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         len_q     <= '0;
         byte_idx  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         buf_data  <= '0;
         buf_valid <= 1'b0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
      end else begin
         if (accept) begin
            len_q     <= tape_len;
            byte_idx  <= '0;
            buf_valid <= 1'b0;
            mem_rd    <= 1'b1;
            mem_addr  <= '0;
         end
         if (ack_hit) begin
            mem_rd    <= 1'b0;
            buf_data  <= mem_data;
            buf_valid <= 1'b1;
         end
         if (consume) begin
            shreg     <= {1'b0, buf_data[7:1]};
            buf_valid <= 1'b0;
            if (!last_byte) begin
               mem_rd   <= 1'b1;
               mem_addr <= byte_idx + ADDR_W'(1);
            end
         end
         if (shift_en) begin
            shreg <= {1'b0, shreg[7:1]};
         end
         if (byte_adv) begin
            byte_idx <= byte_idx + ADDR_W'(1);
         end
         if (cnt_clr) begin
            bit_cnt <= '0;
         end else if (cnt_inc) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cas_tape_player.sv
// Self-checking bench for cas_tape_player: a cell-level reference waveform
// built from the framing rules is compared against tape_out every cycle.
module tb_cas_tape_player;

   localparam int ADDR_W = 16;
   localparam int HALF0  = 4;
   localparam int HALF1  = 2;
   localparam int LEADER = 2;

   logic              clk_sys = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] tape_len;
   logic              fast_i;
   logic              motor_i;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [7:0]        mem_data;
   logic              tape_out;
   logic              busy;
   logic              done;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0]        mem_img [0:15];
   bit                exp_q[$];
   logic [ADDR_W-1:0] rd_log[$];

   int  w          = 0;
   bit  run        = 1'b0;
   bit  motor_prev = 1'b1;
   bit  last_exp   = 1'b0;
   int  done_at    = 0;
   int  rd_idx     = 0;
   int  wait_cnt   = 0;
   int  ack_delay  = 1;
   int  stall_read = -1;
   int  stall_w    = 0;
   bit  force_ack  = 1'b0;
   bit  go;

   cas_tape_player #(
      .ADDR_W      (ADDR_W),
      .HALF0_CYC   (HALF0),
      .HALF1_CYC   (HALF1),
      .LEADER_BITS (LEADER)
   ) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .start    (start),
      .tape_len (tape_len),
      .fast_i   (fast_i),
      .motor_i  (motor_i),
      .mem_rd   (mem_rd),
      .mem_addr (mem_addr),
      .mem_ack  (mem_ack),
      .mem_data (mem_data),
      .tape_out (tape_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: half period for a bit value under the speed setting.
   function automatic int halfFor(input bit b, input bit fast);
      int h;
      h = b ? HALF1 : HALF0;
      if (fast) begin
         h = h / 4;
         if (h < 1) h = 1;
      end
      return h;
   endfunction

   task automatic pushCell(input bit b, input bit fast);
      int h;
      h = halfFor(b, fast);
      for (int i = 0; i < h; i++) exp_q.push_back(1'b1);
      for (int i = 0; i < h; i++) exp_q.push_back(1'b0);
   endtask

   task automatic pushLeader(input bit fast);
      for (int i = 0; i < LEADER; i++) pushCell(1'b1, fast);
   endtask

   task automatic pushByte(input logic [7:0] b, input bit fast);
      pushCell(1'b0, fast);
      for (int i = 0; i < 8; i++) pushCell(b[i], fast);
      pushCell(1'b1, fast);
      pushCell(1'b1, fast);
   endtask

   task automatic pushGap(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
   endtask

   task automatic checkReads(input string tag, input int n);
      checkOutput({tag, "_count"}, rd_log.size(), n);
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s_addr%0d", tag, i),
                     (i < rd_log.size()) ? 32'(rd_log[i]) : 32'hFFFF_FFFF, i);
      end
   endtask

   // Start a playback; waveform cycle 1 is the cycle after start is sampled.
   task automatic applyStimulus(input int len, input bit fast);
      @(posedge clk_sys);
      #1;
      tape_len = ADDR_W'(len);
      fast_i   = fast;
      start    = 1'b1;
      rd_log.delete();
      rd_idx   = 0;
      wait_cnt = 0;
      @(posedge clk_sys);
      #1;
      start      = 1'b0;
      w          = 0;
      motor_prev = 1'b1;
      run        = 1'b1;
   endtask

   task automatic waitEnd(input int limit);
      for (int i = 0; i < limit && run; i++) @(posedge clk_sys);
      if (run) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL timeout_end: still running at w=%0d, expected done", w);
         run = 1'b0;
      end
   endtask

   task automatic waitW(input int n);
      for (int i = 0; i < 2000 && w < n; i++) @(posedge clk_sys);
      if (w < n) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL timeout_cycle: reached w=%0d, expected %0d", w, n);
      end
   endtask

   // Memory responder plus per-cycle comparison against the reference stream.
   initial begin
      mem_ack  = 1'b0;
      mem_data = 8'h00;
      forever begin
         @(negedge clk_sys);
         if (run) w++;
         mem_ack = 1'b0;
         if (force_ack) begin
            mem_ack   = 1'b1;
            mem_data  = 8'h5A;
            force_ack = 1'b0;
         end else if (mem_rd) begin
            if (rd_idx == stall_read) go = (w == stall_w);
            else go = (wait_cnt >= ack_delay);
            if (go) begin
               mem_ack  = 1'b1;
               mem_data = mem_img[mem_addr[3:0]];
               rd_log.push_back(mem_addr);
               rd_idx++;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
         if (run) begin
            if (motor_prev) begin
               if (exp_q.size() == 0) begin
                  checkOutput("done_pulse", done, 1'b1);
                  checkOutput("busy_at_done", busy, 1'b0);
                  checkOutput("tape_at_done", tape_out, 1'b0);
                  done_at = w;
                  run     = 1'b0;
               end else begin
                  last_exp = exp_q.pop_front();
               end
            end
            if (run) begin
               checkOutput($sformatf("tape_out@%0d", w), tape_out, last_exp);
               checkOutput($sformatf("busy@%0d", w), busy, 1'b1);
               checkOutput($sformatf("done@%0d", w), done, 1'b0);
            end
            motor_prev = motor_i;
         end
      end
   end

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      tape_len = '0;
      fast_i   = 1'b0;
      motor_i  = 1'b1;
      for (int i = 0; i < 16; i++) mem_img[i] = 8'h00;

      // Reset state
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      checkOutput("rst_tape", tape_out, 1'b0);
      checkOutput("rst_rd", mem_rd, 1'b0);
      checkOutput("rst_addr", mem_addr, 16'h0000);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      @(posedge clk_sys);
      #1 reset = 1'b0;

      // Single byte 0xA5
      $display("[TB] scenario: single byte");
      mem_img[0] = 8'hA5;
      exp_q.delete();
      pushLeader(1'b0);
      pushByte(8'hA5, 1'b0);
      checkOutput("model_len_t1", exp_q.size(), 72);
      applyStimulus(1, 1'b0);
      waitEnd(400);
      checkOutput("done_cycle_t1", done_at, 73);
      @(negedge clk_sys);
      checkOutput("done_once_t1", done, 1'b0);
      checkOutput("busy_after_t1", busy, 1'b0);
      checkReads("reads_t1", 1);

      // Back-to-back bytes with a stray start while busy
      $display("[TB] scenario: back-to-back");
      mem_img[0] = 8'h00;
      mem_img[1] = 8'hFF;
      mem_img[2] = 8'h55;
      exp_q.delete();
      pushLeader(1'b0);
      pushByte(8'h00, 1'b0);
      pushByte(8'hFF, 1'b0);
      pushByte(8'h55, 1'b0);
      applyStimulus(3, 1'b0);
      waitW(30);
      #1;
      start    = 1'b1;
      tape_len = 16'd9;
      @(posedge clk_sys);
      #1 start = 1'b0;
      waitEnd(800);
      checkOutput("done_cycle_t2", done_at, 201);
      checkReads("reads_t2", 3);

      // Stalled second fetch: 40 cycles of silence after byte 0
      $display("[TB] scenario: stall");
      mem_img[0] = 8'h3C;
      mem_img[1] = 8'h81;
      exp_q.delete();
      pushLeader(1'b0);
      pushByte(8'h3C, 1'b0);
      pushGap(40);
      pushByte(8'h81, 1'b0);
      stall_read = 1;
      stall_w    = 72 + 40;
      applyStimulus(2, 1'b0);
      waitEnd(800);
      stall_read = -1;
      checkOutput("done_cycle_t3", done_at, 185);
      checkReads("reads_t3", 2);

      // Fast load: every half period clamps to one cycle
      $display("[TB] scenario: fast");
      mem_img[0] = 8'h00;
      exp_q.delete();
      pushLeader(1'b1);
      pushByte(8'h00, 1'b1);
      checkOutput("model_len_t4", exp_q.size(), 26);
      applyStimulus(1, 1'b1);
      waitEnd(200);
      #1 fast_i = 1'b0;
      checkOutput("done_cycle_t4", done_at, 27);

      // Motor pause mid-data, then reset mid-byte with a read outstanding
      $display("[TB] scenario: motor and reset");
      mem_img[0] = 8'h96;
      mem_img[1] = 8'h00;
      exp_q.delete();
      pushLeader(1'b0);
      pushByte(8'h96, 1'b0);
      pushByte(8'h00, 1'b0);
      stall_read = 1;
      stall_w    = 100000;
      applyStimulus(2, 1'b0);
      waitW(20);
      #1 motor_i = 1'b0;
      repeat (10) @(posedge clk_sys);
      #1 motor_i = 1'b1;
      waitW(50);
      #1;
      checkOutput("rd_pending_t5", mem_rd, 1'b1);
      reset = 1'b1;
      run   = 1'b0;
      @(posedge clk_sys);
      #1 reset = 1'b0;
      @(negedge clk_sys);
      checkOutput("rst_mid_tape", tape_out, 1'b0);
      checkOutput("rst_mid_busy", busy, 1'b0);
      checkOutput("rst_mid_rd", mem_rd, 1'b0);
      @(posedge clk_sys);
      #1 force_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_sys);
         checkOutput($sformatf("late_ack_rd%0d", i), mem_rd, 1'b0);
         checkOutput($sformatf("late_ack_busy%0d", i), busy, 1'b0);
         checkOutput($sformatf("late_ack_tape%0d", i), tape_out, 1'b0);
         checkOutput($sformatf("late_ack_done%0d", i), done, 1'b0);
      end
      stall_read = -1;

      // Zero-length tape
      $display("[TB] scenario: zero length");
      @(posedge clk_sys);
      #1;
      tape_len = '0;
      start    = 1'b1;
      @(posedge clk_sys);
      #1 start = 1'b0;
      @(negedge clk_sys);
      checkOutput("len0_done", done, 1'b1);
      checkOutput("len0_busy", busy, 1'b0);
      checkOutput("len0_rd", mem_rd, 1'b0);
      @(negedge clk_sys);
      checkOutput("len0_done_once", done, 1'b0);
      checkOutput("len0_busy2", busy, 1'b0);
      checkOutput("len0_rd2", mem_rd, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
